// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;
  localparam int REG_W_MAX = 8;
  typedef logic [REG_W_MAX-1:0] reg_idx_t;
  localparam reg_idx_t XZR = reg_idx_t'(31);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    logic     regWrite;
    logic     memRead;
    logic     branch;
    reg_idx_t rn;
    reg_idx_t rm;
    logic     use_rn;
    logic     use_rm;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  // XZR is never a real producer, so it never matches.
  function automatic logic reg_match(stage_t p, reg_idx_t idx);
    return p.valid && p.regWrite && (p.rd == idx) && (idx != XZR);
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode/execute side bus between the pipeline datapath and the hazard controller.
interface hazard_ctrl_if #(parameter int REG_W = 5, parameter int CNT_W = 16);
  logic             valid_D;
  logic [REG_W-1:0] rn_D, rm_D, rd_D;
  logic             use_rn_D, use_rm_D;
  logic             regWrite_D, memRead_D, branch_D;
  logic             zero_E;
  logic             halt_req;
  logic             stall_F, stall_D, flush_D, flush_E, pcSrc;
  logic [1:0]       forwardA, forwardB;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output valid_D, rn_D, rm_D, rd_D, use_rn_D, use_rm_D,
           regWrite_D, memRead_D, branch_D, zero_E, halt_req,
    input  stall_F, stall_D, flush_D, flush_E, pcSrc,
           forwardA, forwardB, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  valid_D, rn_D, rm_D, rd_D, use_rn_D, use_rm_D,
           regWrite_D, memRead_D, branch_D, zero_E, halt_req,
    output stall_F, stall_D, flush_D, flush_E, pcSrc,
           forwardA, forwardB, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_cnt.sv
// Saturating event counter; sticks at all-ones.
module hazard_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward control for a 5-stage pipeline with a drain-and-halt FSM.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input logic         clk,
  input logic         reset,
  hazard_ctrl_if.slave bus
);
  state_t     state, state_nxt;
  stage_t     e_q, m_q, w_q, d_rec, e_nxt;
  logic       taken, load_use, stall_inc, flush_inc;
  logic       s_f, s_d, f_d, f_e, pc_sel;
  logic [1:0] fwd_a, fwd_b;
  logic       unused_bits;

  function automatic reg_idx_t widen(logic [REG_W-1:0] r);
    widen = '0;
    widen[REG_W-1:0] = r;
  endfunction

  // Outside RUN the decode slot is treated as a bubble.
  always_comb begin
    d_rec          = BUBBLE;
    d_rec.valid    = bus.valid_D && (state == RUN);
    d_rec.rd       = widen(bus.rd_D);
    d_rec.rn       = widen(bus.rn_D);
    d_rec.rm       = widen(bus.rm_D);
    d_rec.use_rn   = bus.use_rn_D;
    d_rec.use_rm   = bus.use_rm_D;
    d_rec.regWrite = bus.regWrite_D;
    d_rec.memRead  = bus.memRead_D;
    d_rec.branch   = bus.branch_D;
  end

  assign taken    = e_q.valid && e_q.branch && bus.zero_E;
  assign load_use = d_rec.valid && e_q.valid && e_q.memRead &&
                    ((d_rec.use_rn && reg_match(e_q, d_rec.rn)) ||
                     (d_rec.use_rm && reg_match(e_q, d_rec.rm)));

  always_comb begin
    state_nxt = state;
    s_f       = 1'b0;
    s_d       = 1'b0;
    f_d       = 1'b0;
    f_e       = 1'b0;
    pc_sel    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;

    if (e_q.use_rn && reg_match(m_q, e_q.rn))      fwd_a = FWD_MEM;
    else if (e_q.use_rn && reg_match(w_q, e_q.rn)) fwd_a = FWD_WB;
    if (e_q.use_rm && reg_match(m_q, e_q.rm))      fwd_b = FWD_MEM;
    else if (e_q.use_rm && reg_match(w_q, e_q.rm)) fwd_b = FWD_WB;

    unique case (state)
      RUN: begin
        // A taken branch squashes the stalled consumer anyway, so it wins.
        if (taken) begin
          pc_sel    = 1'b1;
          f_d       = 1'b1;
          f_e       = 1'b1;
          flush_inc = 1'b1;
        end else if (load_use) begin
          s_f       = 1'b1;
          s_d       = 1'b1;
          f_e       = 1'b1;
          stall_inc = 1'b1;
        end
        if (bus.halt_req) state_nxt = DRAIN;
      end
      DRAIN: begin
        s_f = 1'b1;
        f_d = 1'b1;
        if (taken) begin
          pc_sel    = 1'b1;
          f_e       = 1'b1;
          flush_inc = 1'b1;
        end
        if (!e_q.valid && !m_q.valid && !w_q.valid) state_nxt = HALTED;
      end
      HALTED: begin
        s_f   = 1'b1;
        s_d   = 1'b1;
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
      end
      default: state_nxt = RUN;
    endcase

    e_nxt = f_e ? BUBBLE : d_rec;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= BUBBLE;
      m_q <= BUBBLE;
      w_q <= BUBBLE;
    end else begin
      e_q <= e_nxt;
      m_q <= e_q;
      w_q <= m_q;
    end
  end

  hazard_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .en(stall_inc), .cnt(bus.stall_cnt)
  );
  hazard_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .en(flush_inc), .cnt(bus.flush_cnt)
  );

  // Reset masks the combinational outputs so they read zero immediately.
  assign bus.stall_F  = !reset && s_f;
  assign bus.stall_D  = !reset && s_d;
  assign bus.flush_D  = !reset && f_d;
  assign bus.flush_E  = !reset && f_e;
  assign bus.pcSrc    = !reset && pc_sel;
  assign bus.forwardA = reset ? FWD_RF : fwd_a;
  assign bus.forwardB = reset ? FWD_RF : fwd_b;
  assign bus.halted   = !reset && (state == HALTED);

  assign unused_bits = ^{m_q, w_q};
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed checks of stall, flush, forwarding, drain/halt and counter saturation.
module tb_hazard_ctrl;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.REG_W(5), .CNT_W(CNT_W)) hif ();
  hazard_ctrl #(.REG_W(5), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(hif));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {stall_F, stall_D, flush_D, flush_E, pcSrc}
  function automatic logic [4:0] hz();
    return {hif.stall_F, hif.stall_D, hif.flush_D, hif.flush_E, hif.pcSrc};
  endfunction

  task automatic drv(input logic v, input logic [4:0] rd, input logic [4:0] rn,
                     input logic [4:0] rm, input logic urn, input logic urm,
                     input logic rw, input logic mr, input logic br);
    hif.valid_D = v;   hif.rd_D = rd;     hif.rn_D = rn;     hif.rm_D = rm;
    hif.use_rn_D = urn; hif.use_rm_D = urm;
    hif.regWrite_D = rw; hif.memRead_D = mr; hif.branch_D = br;
  endtask

  task automatic nop();  drv(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic step(); @(posedge clk); #1; endtask
  task automatic smp();  @(negedge clk); endtask
  task automatic do_rst(); reset = 1'b1; step(); reset = 1'b0; endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    hif.zero_E = 1'b1; hif.halt_req = 1'b0;
    drv(1, 2, 2, 2, 1, 1, 1, 1, 1);
    #2;
    chk("rst_hz", 32'(hz()), 0);
    chk("rst_fwd", {hif.forwardA, hif.forwardB}, 0);
    chk("rst_halt", 32'(hif.halted), 0);
    chk("rst_cnt", {hif.stall_cnt, hif.flush_cnt}, 0);
    @(posedge clk); #1;
    reset = 1'b0; hif.zero_E = 1'b0; nop();

    // load-use: LDUR X2 then ADD X4,X2,X5
    drv(1, 2, 1, 0, 1, 0, 1, 1, 0); step();
    drv(1, 4, 2, 5, 1, 1, 1, 0, 0); smp();
    chk("lu_hz", 32'(hz()), 5'b11010);
    chk("lu_cnt0", 32'(hif.stall_cnt), 0);
    step(); smp();
    chk("lu_once", 32'(hz()), 0);
    chk("lu_cnt1", 32'(hif.stall_cnt), 1);
    step(); nop(); smp();
    chk("lu_fwdA", 32'(hif.forwardA), 2'b01);
    chk("lu_fwdB", 32'(hif.forwardB), 2'b00);

    // X3 producers in M and W, consumer reads X3
    drv(1, 3, 1, 0, 1, 0, 1, 0, 0); step();
    drv(1, 3, 1, 0, 1, 0, 1, 0, 0); step();
    drv(1, 8, 3, 7, 1, 1, 1, 0, 0); step(); nop(); smp();
    chk("fwd_mem_a", 32'(hif.forwardA), 2'b10);
    chk("fwd_none_b", 32'(hif.forwardB), 2'b00);
    // M now writes X9: A falls back to W, B picks up M
    drv(1, 3, 1, 0, 1, 0, 1, 0, 0); step();
    drv(1, 9, 1, 0, 1, 0, 1, 0, 0); step();
    drv(1, 8, 3, 9, 1, 1, 1, 0, 0); step(); nop(); smp();
    chk("fwd_wb_a", 32'(hif.forwardA), 2'b01);
    chk("fwd_mem_b", 32'(hif.forwardB), 2'b10);

    // XZR load producer: no stall, no forward
    drv(1, 31, 1, 0, 1, 0, 1, 1, 0); step();
    drv(1, 8, 31, 31, 1, 1, 1, 0, 0); smp();
    chk("xzr_nostall", 32'(hz()), 0);
    step(); nop(); smp();
    chk("xzr_fwd", {hif.forwardA, hif.forwardB}, 0);
    // use flags gate matching
    drv(1, 5, 0, 0, 0, 0, 1, 0, 0); step();
    drv(1, 6, 5, 5, 0, 1, 1, 0, 0); step(); nop(); smp();
    chk("use_gate", {hif.forwardA, hif.forwardB}, 4'b0010);

    // taken branch overrides simultaneous load-use
    do_rst();
    drv(1, 6, 1, 0, 1, 0, 1, 1, 1); step();
    drv(1, 7, 6, 0, 1, 0, 1, 0, 0); hif.zero_E = 1'b1; smp();
    chk("br_hz", 32'(hz()), 5'b00111);
    step(); hif.zero_E = 1'b0; nop(); smp();
    chk("br_fcnt", 32'(hif.flush_cnt), 1);
    chk("br_scnt", 32'(hif.stall_cnt), 0);
    chk("br_after", 32'(hz()), 0);
    // CBZ not taken, then zero_E rises mid-cycle
    drv(1, 0, 1, 0, 1, 0, 0, 0, 1); step(); nop(); smp();
    chk("nt_hz", 32'(hz()), 0);
    #1 hif.zero_E = 1'b1; #1;
    chk("tk_comb", 32'(hz()), 5'b00111);
    step(); hif.zero_E = 1'b0; smp();
    chk("tk_fcnt", 32'(hif.flush_cnt), 2);

    // drain with three valid instructions in flight
    do_rst();
    drv(1, 1, 0, 0, 0, 0, 1, 0, 0); step();
    drv(1, 2, 0, 0, 0, 0, 1, 0, 0); step();
    drv(1, 3, 0, 0, 0, 0, 1, 0, 0); step();
    nop(); hif.halt_req = 1'b1; smp();
    chk("hlt_pre", 32'(hif.halted), 0);
    step(); hif.halt_req = 1'b0;
    drv(1, 9, 1, 2, 1, 1, 1, 0, 0); smp();
    chk("drn_hz", 32'(hz()), 5'b10100);
    chk("drn_h0", 32'(hif.halted), 0);
    step(); smp(); chk("drn_h1", 32'(hif.halted), 0);
    step(); smp(); chk("drn_h2", 32'(hif.halted), 0);
    step(); smp(); chk("hlt_on", 32'(hif.halted), 1);
    chk("hlt_hz", 32'(hz()), 5'b11000);
    chk("hlt_fwd", {hif.forwardA, hif.forwardB}, 0);
    hif.halt_req = 1'b1; step(); step(); step(); hif.halt_req = 1'b0; smp();
    chk("hlt_stay", 32'(hif.halted), 1);

    // stall counter saturation
    do_rst();
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drv(1, 2, 1, 0, 1, 0, 1, 1, 0); step();
      drv(1, 4, 2, 5, 1, 1, 1, 0, 0); step();
      if (i == 4) chk("sat_mid", 32'(hif.stall_cnt), 5);
    end
    smp();
    chk("sat_top", 32'(hif.stall_cnt), 32'((1 << CNT_W) - 1));
    // async reset mid-stall
    drv(1, 2, 1, 0, 1, 0, 1, 1, 0); step();
    drv(1, 4, 2, 5, 1, 1, 1, 0, 0); smp();
    chk("pre_rst_hz", 32'(hz()), 5'b11010);
    #1 reset = 1'b1; #1;
    chk("arst_hz", 32'(hz()), 0);
    chk("arst_cnt", {hif.stall_cnt, hif.flush_cnt}, 0);
    chk("arst_halt", 32'(hif.halted), 0);
    step(); reset = 1'b0; smp();
    chk("post_rst_hz", 32'(hz()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
